// File: rtl/dmi_initiator.sv
// DMI initiator: turns one host command into one DMI transaction.
// Busy responses are re-issued after a short idle gap, and every transaction
// is guarded by a timeout that also pulses the DMI-side reset.
module dmi_initiator #(
    parameter int unsigned MaxRetries    = 4,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned RetryGap      = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // Host command side
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [6:0]  cmd_addr_i,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_wdata_i,
    // Host result side
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_rdata_o,
    output logic [1:0]  res_status_o,
    output logic [2:0]  res_retries_o,
    // DMI requester side
    output logic        dmi_rst_no,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [40:0] dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [33:0] dmi_resp_i
);

    localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int unsigned GW = (RetryGap > 1) ? $clog2(RetryGap) : 1;

    localparam logic [TW-1:0] TimerLast = TW'(TimeoutCycles - 1);
    localparam logic [RW-1:0] RetryMax  = RW'(MaxRetries);
    localparam logic [GW-1:0] GapLast   = GW'(RetryGap - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq  = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StGap  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;

    localparam logic [1:0] RespOk   = 2'd0;
    localparam logic [1:0] RespBusy = 2'd3;

    localparam logic [1:0] StatOk      = 2'd0;
    localparam logic [1:0] StatTimeout = 2'd1;
    localparam logic [1:0] StatFail    = 2'd2;
    localparam logic [1:0] StatBusy    = 2'd3;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [40:0]   req_q, req_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    status_q, status_d;
    logic          rst_n_q, rst_n_d;
    logic          timer_expired;

    assign timer_expired = (timer_q == TimerLast);

    // Next-state and result bookkeeping for the single in-flight command.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        gap_d    = gap_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        rst_n_d  = 1'b1;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    retry_d = '0;
                    timer_d = '0;
                    if (cmd_op_i == OpRead || cmd_op_i == OpWrite) begin
                        req_d   = {cmd_addr_i, cmd_op_i, cmd_wdata_i};
                        state_d = StReq;
                    end else begin
                        // Illegal op: report failure without touching the DMI.
                        status_d = StatFail;
                        rdata_d  = '0;
                        state_d  = StDone;
                    end
                end
            end
            StReq: begin
                timer_d = timer_q + TW'(1);
                // A request handshake does not complete the transaction, so the
                // timeout wins here and the DMI reset pulse flushes it.
                if (timer_expired) begin
                    status_d = StatTimeout;
                    rdata_d  = '0;
                    rst_n_d  = 1'b0;
                    state_d  = StDone;
                end else if (dmi_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                timer_d = timer_q + TW'(1);
                // A response on the expiry cycle takes priority over the timeout.
                if (dmi_resp_valid_i) begin
                    case (dmi_resp_i[1:0])
                        RespOk: begin
                            rdata_d  = dmi_resp_i[33:2];
                            status_d = StatOk;
                            state_d  = StDone;
                        end
                        RespBusy: begin
                            if (retry_q < RetryMax) begin
                                retry_d = retry_q + RW'(1);
                                gap_d   = '0;
                                state_d = StGap;
                            end else begin
                                status_d = StatBusy;
                                rdata_d  = '0;
                                state_d  = StDone;
                            end
                        end
                        default: begin
                            status_d = StatFail;
                            rdata_d  = '0;
                            state_d  = StDone;
                        end
                    endcase
                end else if (timer_expired) begin
                    status_d = StatTimeout;
                    rdata_d  = '0;
                    rst_n_d  = 1'b0;
                    state_d  = StDone;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    timer_d = '0;
                    state_d = StReq;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            retry_q  <= '0;
            gap_q    <= '0;
            req_q    <= '0;
            rdata_q  <= '0;
            status_q <= StatOk;
            rst_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            gap_q    <= gap_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            rst_n_q  <= rst_n_d;
        end
    end

    // Outputs are decoded only from registers.
    assign cmd_ready_o      = (state_q == StIdle);
    assign res_valid_o      = (state_q == StDone);
    assign res_rdata_o      = rdata_q;
    assign res_status_o     = status_q;
    assign res_retries_o    = 3'(retry_q);
    assign dmi_rst_no       = rst_n_q;
    assign dmi_req_valid_o  = (state_q == StReq);
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = (state_q == StWait);

endmodule

// File: tb/tb_dmi_initiator.sv
// Directed bench for dmi_initiator with a small configurable DMI responder.
module tb_dmi_initiator;

    localparam int RetryGap = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready_o;
    logic [6:0]  cmd_addr;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_wdata;
    logic        res_valid_o;
    logic        res_ready;
    logic [31:0] res_rdata_o;
    logic [1:0]  res_status_o;
    logic [2:0]  res_retries_o;
    logic        dmi_rst_no;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready;
    logic [40:0] dmi_req_o;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready_o;
    logic [33:0] dmi_resp;

    // Responder configuration and observations
    bit          dm_ready_cfg = 1'b1;
    int          resp_delay   = 0;
    int          busy_left    = 0;
    logic [1:0]  final_code   = 2'd0;
    logic [31:0] resp_data    = '0;
    logic [40:0] exp_req      = '0;
    logic [40:0] last_req     = '0;
    int          req_hs = 0, req_bad = 0, gap_bad = 0, rst_low = 0;
    int          cyc = 0, last_busy_cyc = 0, wait_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmi_initiator #(
        .MaxRetries   (4),
        .TimeoutCycles(1024),
        .RetryGap     (RetryGap)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_addr_i      (cmd_addr),
        .cmd_op_i        (cmd_op),
        .cmd_wdata_i     (cmd_wdata),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready),
        .res_rdata_o     (res_rdata_o),
        .res_status_o    (res_status_o),
        .res_retries_o   (res_retries_o),
        .dmi_rst_no      (dmi_rst_no),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready),
        .dmi_req_o       (dmi_req_o),
        .dmi_resp_valid_i(dmi_resp_valid),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_i      (dmi_resp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DMI responder: decides inputs at each falling edge for the next rising edge.
    initial begin
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (dmi_rst_no !== 1'b1) rst_low++;
            dmi_req_ready = dm_ready_cfg;
            if (dmi_req_valid_o && dm_ready_cfg) begin
                req_hs++;
                last_req = dmi_req_o;
                if (dmi_req_o !== exp_req) req_bad++;
                if (req_hs > 1 && (cyc - last_busy_cyc - 1) != RetryGap) gap_bad++;
                wait_cnt = 0;
            end
            dmi_resp_valid = 1'b0;
            if (dmi_resp_ready_o) begin
                if (wait_cnt == resp_delay) begin
                    dmi_resp_valid = 1'b1;
                    if (busy_left > 0) begin
                        dmi_resp      = {32'hDEAD_BEEF, 2'b11};
                        busy_left     = busy_left - 1;
                        last_busy_cyc = cyc;
                    end else begin
                        dmi_resp = {resp_data, final_code};
                    end
                end
                wait_cnt++;
            end
        end
    end

    // One command end to end; lat counts rising edges from acceptance to res_valid.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [6:0] addr,
                          input logic [31:0] wd, input logic [1:0] st, input logic [31:0] rd,
                          input int rtr, input int hs, input int lat, input int rlow);
        int n;
        bit seen;
        @(negedge clk);
        req_hs = 0; req_bad = 0; gap_bad = 0; rst_low = 0;
        exp_req = {addr, op, wd};
        check_eq({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            if (res_valid_o) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check_eq({tag, "_res_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_latency"}, 64'(n), 64'(lat));
        check_eq({tag, "_status"}, 64'(res_status_o), 64'(st));
        check_eq({tag, "_rdata"}, 64'(res_rdata_o), 64'(rd));
        check_eq({tag, "_retries"}, 64'(res_retries_o), 64'(rtr));
        check_eq({tag, "_rst_n_first_done"}, 64'(dmi_rst_no), (rlow != 0) ? 64'd0 : 64'd1);
        @(negedge clk);
        check_eq({tag, "_status_held"}, 64'(res_status_o), 64'(st));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({tag, "_res_cleared"}, 64'(res_valid_o), 64'd0);
        check_eq({tag, "_req_hs"}, 64'(req_hs), 64'(hs));
        check_eq({tag, "_req_stable"}, 64'(req_bad), 64'd0);
        check_eq({tag, "_gap"}, 64'(gap_bad), 64'd0);
        check_eq({tag, "_rst_low_cycles"}, 64'(rst_low), 64'(rlow));
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_op = '0; cmd_wdata = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("reset_res_valid", 64'(res_valid_o), 64'd0);
        check_eq("reset_req_valid", 64'(dmi_req_valid_o), 64'd0);
        check_eq("reset_rst_n", 64'(dmi_rst_no), 64'd1);
        rst = 1'b0;

        dm_ready_cfg = 1'b1; resp_delay = 0; busy_left = 0; final_code = 2'd0;
        resp_data = 32'h1234_5678;
        do_cmd("write", 2'd2, 7'h10, 32'h1, 2'd0, 32'h1234_5678, 0, 1, 3, 0);
        check_eq("write_req_word", 64'(last_req), 64'h042_0000_0001);

        resp_delay = 5; resp_data = 32'hCAFE_F00D;
        do_cmd("read", 2'd1, 7'h11, 32'h0, 2'd0, 32'hCAFE_F00D, 0, 1, 8, 0);
        check_eq("read_req_word", 64'(last_req), 64'h045_0000_0000);

        resp_delay = 0; busy_left = 2; resp_data = 32'h0BAD_CAFE;
        do_cmd("busy2", 2'd1, 7'h22, 32'h0, 2'd0, 32'h0BAD_CAFE, 2, 3, 11, 0);

        do_cmd("illegal0", 2'd0, 7'h05, 32'h55, 2'd2, 32'h0, 0, 0, 1, 0);

        busy_left = 100;
        do_cmd("busy_exh", 2'd2, 7'h33, 32'hFFFF_0000, 2'd3, 32'h0, 4, 5, 19, 0);
        busy_left = 0;

        final_code = 2'd2; resp_data = 32'hFFFF_FFFF;
        do_cmd("resp_fail", 2'd1, 7'h04, 32'h0, 2'd2, 32'h0, 0, 1, 3, 0);
        final_code = 2'd0; resp_data = 32'h7777_1111;
        do_cmd("read_ok", 2'd1, 7'h04, 32'h0, 2'd0, 32'h7777_1111, 0, 1, 3, 0);
        final_code = 2'd1;
        do_cmd("resp_rsvd", 2'd1, 7'h04, 32'h0, 2'd2, 32'h0, 0, 1, 3, 0);
        final_code = 2'd0;
        do_cmd("illegal3", 2'd3, 7'h7F, 32'h0, 2'd2, 32'h0, 0, 0, 1, 0);

        dm_ready_cfg = 1'b0;
        do_cmd("timeout_req", 2'd1, 7'h01, 32'h0, 2'd1, 32'h0, 0, 0, 1025, 1);
        dm_ready_cfg = 1'b1; resp_delay = 5000;
        do_cmd("timeout_wait", 2'd2, 7'h02, 32'h9, 2'd1, 32'h0, 0, 1, 1025, 1);
        resp_delay = 1022; resp_data = 32'hA5A5_5A5A;
        do_cmd("resp_on_to", 2'd1, 7'h03, 32'h0, 2'd0, 32'hA5A5_5A5A, 0, 1, 1025, 0);

        // Reset while waiting for a response
        resp_delay = 5000;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 7'h3C; cmd_wdata = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!dmi_resp_ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_reach_wait", 64'(dmi_resp_ready_o), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("rst_res_valid", 64'(res_valid_o), 64'd0);
        check_eq("rst_rdata", 64'(res_rdata_o), 64'd0);
        check_eq("rst_status", 64'(res_status_o), 64'd0);
        check_eq("rst_retries", 64'(res_retries_o), 64'd0);
        check_eq("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
        check_eq("rst_req", 64'(dmi_req_o), 64'd0);
        check_eq("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check_eq("rst_rst_n", 64'(dmi_rst_no), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("post_rst_no_result", 64'(res_valid_o), 64'd0);

        resp_delay = 0; resp_data = 32'h0000_00AA;
        do_cmd("post_rst_write", 2'd2, 7'h10, 32'h2, 2'd0, 32'h0000_00AA, 0, 1, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmi_initiator.md
# dmi_initiator

DMI initiator that drives the debug module's DMI slave port from a simple command/result handshake interface. It sits between a host-side agent (UART debug bridge, CPU-visible mailbox, or test sequencer) and the debug module. It turns one command into one DMI transaction, retries DMI busy responses, and guards every transaction with a timeout. It is the requester end of the same 41-bit request / 34-bit response DMI link the debug module consumes.

## Interface
- `MaxRetries`, default 4: number of re-issues allowed after a busy (2'b11) DMI response.
- `TimeoutCycles`, default 1024: cycles allowed from request issue to response. Must be ≥ 2.
- `RetryGap`, default 2: idle cycles inserted before each re-issue. Must be ≥ 1.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when valid && ready.
- `cmd_addr_i` in 7: DMI register address.
- `cmd_op_i` in 2: 1 = read, 2 = write. 0 and 3 are illegal.
- `cmd_wdata_i` in 32: write data.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result consumed when valid && ready.
- `res_rdata_o` out 32: response data.
- `res_status_o` out 2: 0 = ok, 1 = timeout, 2 = failed/illegal, 3 = busy exhausted.
- `res_retries_o` out 3: number of re-issues used.
- `dmi_rst_no` out 1: DMI-side reset, active-low. Pulsed low on timeout.
- `dmi_req_valid_o` out 1: DMI request valid.
- `dmi_req_ready_i` in 1: DMI request ready.
- `dmi_req_o` out 41: {addr[40:34], op[33:32], data[31:0]}.
- `dmi_resp_valid_i` in 1: DMI response valid.
- `dmi_resp_ready_o` out 1: DMI response ready.
- `dmi_resp_i` in 34: {data[33:2], resp[1:0]}. resp: 0 = success, 2 = failed, 3 = busy.

## Operation
- States: IDLE, REQ, WAIT, GAP, DONE. Reset enters IDLE.
- Reset values: `cmd_ready_o`=1, `res_valid_o`=0, `res_rdata_o`=0, `res_status_o`=0, `res_retries_o`=0, `dmi_req_valid_o`=0, `dmi_req_o`=0, `dmi_resp_ready_o`=0, `dmi_rst_no`=1.
- IDLE:
  - `cmd_ready_o`=1.
  - On accept with legal op: latch addr/op/wdata into `dmi_req_o`, clear the retry count and timeout counter, go to REQ.
  - On accept with illegal op (0 or 3): go to DONE with status 2 and rdata 0. No DMI traffic is issued.
- REQ: `dmi_req_valid_o`=1 and `dmi_req_o` held stable until `dmi_req_ready_i`. On the handshake, go to WAIT.
- WAIT: `dmi_resp_ready_o`=1. On `dmi_resp_valid_i`:
  - resp=0: rdata = resp data, status 0, go to DONE.
  - resp=2 (or the reserved value 1): status 2, go to DONE.
  - resp=3 and retry count < MaxRetries: increment the count, go to GAP.
  - resp=3 and retry count = MaxRetries: status 3, go to DONE.
- GAP: wait RetryGap cycles, then go to REQ with the identical request and the timeout counter cleared.
- Timeout:
  - The counter increments every cycle in REQ and WAIT. When it reaches TimeoutCycles-1 with no completing handshake that cycle, status becomes 1 and the state goes to DONE.
  - `dmi_rst_no` is driven low for exactly 1 cycle (the first DONE cycle). This flushes any stale DMI transaction.
- DONE: `res_valid_o`=1 with rdata/status/retries held stable. On `res_ready_i`, go to IDLE.
- `cmd_ready_o` is 1 only in IDLE. Exactly one command is in flight.
- Width rules: the retry counter saturates at MaxRetries and `res_retries_o` is zero-extended. The timeout counter is $clog2(TimeoutCycles) bits.
- `rdata` is updated only on a resp=0 response. It is 0 for every non-ok status.

## Timing
- Command accepted at edge N → `dmi_req_valid_o`=1 from N+1.
- Request handshake at edge M → `dmi_resp_ready_o`=1 from M+1.
- Response handshake at edge K → `res_valid_o`=1 from K+1.
- Best-case latency with ready always 1 and the response in the first WAIT cycle: command accept to `res_valid_o` = 3 cycles.
- Each busy retry adds RetryGap+2 cycles.
- Response and timeout in the same cycle: the response wins, and no timeout or `dmi_rst_no` pulse occurs.
- A response arriving in REQ is ignored because `dmi_resp_ready_o`=0.
- `rst_i` asserted mid-transaction: all outputs take their reset values immediately (asynchronously), the in-flight transaction is dropped, and no result is produced.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Write: cmd op=2, addr 0x10, wdata 0x0000_0001, DMI ready and resp immediate with resp=0 → `dmi_req_o`=0x10<<34 | 2<<32 | 1; result status 0, retries 0; `res_valid_o` at command+3.
- Read: cmd op=1, addr 0x11, DM returns data 0xCAFE_F00D resp=0 after 5 cycles → rdata 0xCAFEF00D, status 0.
- Busy retry: DM returns resp=3 twice, then resp=0 → 3 request handshakes with identical `dmi_req_o`, at least RetryGap idle cycles between them; retries 2, status 0.
- Busy exhausted: DM always returns resp=3 → MaxRetries+1 = 5 requests, status 3, retries 4.
- Timeout: `dmi_req_ready_i` held 0 → DONE after 1024 cycles in REQ, status 1, `dmi_rst_no` low for exactly 1 cycle. A second timeout test with ready=1 and no response gives the same result. A response arriving on the timeout cycle gives status 0.
- Illegal op 0 → immediate DONE with status 2 and no `dmi_req_valid_o`. `rst_i` asserted during WAIT → all outputs at reset values and `cmd_ready_o`=1 after release.
